// File: rtl/tick_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : tick_sched_pkg
// Purpose  : Shared helpers for the tick scheduler (channel-index width,
//            round-robin pick).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tick_sched_pkg;

  // Upper bound on channel count that the round-robin helper can scan.
  localparam int MAX_CH   = 32;
  localparam int MAX_CH_W = $clog2(MAX_CH);

  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Index of the first set request at or after ptr, wrapping modulo n.
  // Returns 0 when nothing is requested; callers qualify with |req.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = ptr + k;
      if (idx >= n) idx -= n;
      if (!found && (k < n) && req[idx[MAX_CH_W-1:0]]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
//------------------------------------------------------------------------------
// Module   : tick_prescaler
// Purpose  : Divides clk into a one-cycle tick every PRESCALE enabled cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int            CW     = $clog2(PRESCALE);
  localparam logic [CW-1:0] c_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == c_LAST);
  assign tick   = enable && w_wrap;

  // Count holds while disabled so timing resumes at the same phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_sched.sv
//------------------------------------------------------------------------------
// Module   : tick_sched
// Purpose  : Multi-channel timeout scheduler on a shared prescaled tick with a
//            round-robin valid/ready expiry port. TICK_SCHED_PERIODIC_EN adds
//            auto-reloading channels and per-channel overrun flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 100
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      start_valid,
  input  logic [$clog2(NUM_CH)-1:0] start_ch,
  input  logic [CNT_W-1:0]          start_count,
`ifdef TICK_SCHED_PERIODIC_EN
  input  logic                      start_periodic,
  output logic [NUM_CH-1:0]         overrun,
`endif
  input  logic                      cancel_valid,
  input  logic [$clog2(NUM_CH)-1:0] cancel_ch,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic [NUM_CH-1:0]         armed,
  output logic [NUM_CH-1:0]         pending
);

  localparam int CH_W = ch_width(NUM_CH);

  typedef struct packed {
    logic             armed;
    logic             pending;
    logic [CNT_W-1:0] remaining;
  } ch_status_t;

  logic              w_tick;
  logic              w_load;
  logic              w_any;
  logic [CH_W-1:0]   w_sel;
  logic [MAX_CH-1:0] w_req;
  logic              r_evt_valid;
  logic [CH_W-1:0]   r_evt_ch;
  logic [CH_W-1:0]   r_ptr;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (w_tick)
  );

  always_comb begin
    w_req               = '0;
    w_req[NUM_CH-1:0]   = pending;
  end

  assign w_load = !r_evt_valid || evt_ready;
  assign w_any  = |pending;
  assign w_sel  = CH_W'(rr_pick(w_req, 32'(r_ptr), NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_status_t       r_status;
    logic             w_start;
    logic             w_cancel;
    logic             w_expire;
    logic             w_claim;
    logic             w_periodic;
    logic [CNT_W-1:0] w_reload;

    assign w_start  = start_valid  && (start_ch  == CH_W'(i));
    assign w_cancel = cancel_valid && (cancel_ch == CH_W'(i));
    assign w_expire = w_tick && r_status.armed && (r_status.remaining == CNT_W'(1));
    assign w_claim  = w_load && w_any && (w_sel == CH_W'(i));

`ifdef TICK_SCHED_PERIODIC_EN
    logic             r_periodic;
    logic [CNT_W-1:0] r_reload;
    logic             r_overrun;

    assign w_periodic = r_periodic;
    assign w_reload   = r_reload;
    assign overrun[i] = r_overrun;

    // An expiry landing on a still-queued expiry is lost and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_periodic <= 1'b0;
        r_reload   <= '0;
        r_overrun  <= 1'b0;
      end else if (w_start) begin
        r_periodic <= start_periodic;
        r_reload   <= start_count;
        r_overrun  <= 1'b0;
      end else if (w_cancel) begin
        r_overrun  <= 1'b0;
      end else if (w_expire && r_status.pending && !w_claim) begin
        r_overrun  <= 1'b1;
      end
    end
`else
    assign w_periodic = 1'b0;
    assign w_reload   = '0;
`endif

    // Priority: start > cancel > expiry > claim by the event register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_status <= '0;
      end else if (w_start) begin
        r_status.remaining <= start_count;
        r_status.armed     <= (start_count != '0);
        r_status.pending   <= (start_count == '0);
      end else if (w_cancel) begin
        r_status <= '0;
      end else begin
        if (w_claim) begin
          r_status.pending <= 1'b0;
        end
        if (w_tick && r_status.armed) begin
          if (w_expire) begin
            r_status.pending <= 1'b1;
            if (w_periodic) begin
              r_status.remaining <= w_reload;
            end else begin
              r_status.armed     <= 1'b0;
              r_status.remaining <= '0;
            end
          end else begin
            r_status.remaining <= r_status.remaining - CNT_W'(1);
          end
        end
      end
    end

    assign armed[i]   = r_status.armed;
    assign pending[i] = r_status.pending;
  end

  // A presented event is held until accepted regardless of channel activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_evt_valid <= 1'b1;
        r_evt_ch    <= w_sel;
        r_ptr       <= (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + CH_W'(1);
      end else begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;

endmodule

`default_nettype wire

// File: tb/tb_tick_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_tick_sched
// Purpose  : Directed self-checking bench for tick_sched (PRESCALE=4, 4 ch).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_sched;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 16;
  localparam int PRESCALE = 4;
  localparam int CH_W     = 2;

  logic              clk          = 1'b0;
  logic              reset_n      = 1'b0;
  logic              enable       = 1'b0;
  logic              start_valid  = 1'b0;
  logic [CH_W-1:0]   start_ch     = '0;
  logic [CNT_W-1:0]  start_count  = '0;
  logic              cancel_valid = 1'b0;
  logic [CH_W-1:0]   cancel_ch    = '0;
  logic              evt_ready    = 1'b0;
  logic              evt_valid;
  logic [CH_W-1:0]   evt_ch;
  logic [NUM_CH-1:0] armed;
  logic [NUM_CH-1:0] pending;
`ifdef TICK_SCHED_PERIODIC_EN
  logic              start_periodic = 1'b0;
  logic [NUM_CH-1:0] overrun;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ph    = 0;  // expected prescaler count in the current cycle
  int base;

  always #5 clk = ~clk;

  tick_sched #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .start_valid    (start_valid),
    .start_ch       (start_ch),
    .start_count    (start_count),
`ifdef TICK_SCHED_PERIODIC_EN
    .start_periodic (start_periodic),
    .overrun        (overrun),
`endif
    .cancel_valid   (cancel_valid),
    .cancel_ch      (cancel_ch),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_ch         (evt_ch),
    .armed          (armed),
    .pending        (pending)
  );

  task automatic step();
    if (enable) ph = (ph + 1) % PRESCALE;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int ch, input int cnt);
    start_valid = 1'b1;
    start_ch    = CH_W'(ch);
    start_count = CNT_W'(cnt);
    step();
    start_valid = 1'b0;
  endtask

  task automatic align();
    while (ph != 0) step();
  endtask

  // Two channels expire on one tick; evt_ready held high throughout.
  task automatic rr_round(input int a, input int b, input int first, input int second);
    evt_ready = 1'b1;
    align();
    base = cyc;
    arm(a, 2);
    arm(b, 2);
    while (cyc < base + 8) step();
    chk("rr_pending", 32'(pending), (32'd1 << a) | (32'd1 << b));
    step();
    chk("rr_first_v", 32'(evt_valid), 32'd1);
    chk("rr_first_ch", 32'(evt_ch), 32'(first));
    step();
    chk("rr_second_ch", 32'(evt_ch), 32'(second));
    step();
    chk("rr_drained", 32'(evt_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    #2 reset_n = 1'b1;
    enable = 1'b1;
    cyc = 0;
    ph  = 0;

    // ch1 count=3 started at cycle 0: ticks at 3,7,11 -> pending at 12
    arm(1, 3);
    chk("t1_armed", 32'(armed), 32'b0010);
    repeat (10) step();
    chk("t1_pend_c11", 32'(pending), 32'd0);
    step();
    chk("t1_pend_c12", 32'(pending), 32'b0010);
    chk("t1_armed_c12", 32'(armed), 32'd0);
    chk("t1_valid_c12", 32'(evt_valid), 32'd0);
    step();
    chk("t1_valid_c13", 32'(evt_valid), 32'd1);
    chk("t1_ch_c13", 32'(evt_ch), 32'd1);
    chk("t1_pend_c13", 32'(pending), 32'd0);
    evt_ready = 1'b1;
    step();
    chk("t1_accept", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // immediate expiry on count 0
    arm(0, 0);
    chk("t2_pend", 32'(pending), 32'b0001);
    chk("t2_armed", 32'(armed), 32'd0);
    step();
    chk("t2_valid", 32'(evt_valid), 32'd1);
    chk("t2_ch", 32'(evt_ch), 32'd0);
    evt_ready = 1'b1;
    step();
    chk("t2_drop", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
    arm(3, 0);
    step();
    chk("t2b_ch3", 32'(evt_ch), 32'd3);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;

    // pointer now 0: ch0/ch2/ch3 expire together, output stalled 5 cycles
    align();
    base = cyc;
    arm(0, 2);
    arm(2, 2);
    arm(3, 2);
    while (cyc < base + 8) step();
    chk("t3_pend", 32'(pending), 32'b1101);
    step();
    chk("t3_valid", 32'(evt_valid), 32'd1);
    chk("t3_first", 32'(evt_ch), 32'd0);
    repeat (4) step();
    chk("t3_hold_v", 32'(evt_valid), 32'd1);
    chk("t3_hold_ch", 32'(evt_ch), 32'd0);
    chk("t3_hold_pend", 32'(pending), 32'b1100);
    evt_ready = 1'b1;
    step();
    chk("t3_second", 32'(evt_ch), 32'd2);
    step();
    chk("t3_third", 32'(evt_ch), 32'd3);
    step();
    chk("t3_empty", 32'(evt_valid), 32'd0);
    rr_round(1, 2, 1, 2);
    rr_round(0, 3, 3, 0);
    evt_ready = 1'b0;

    // cancel after two ticks: no event ever
    align();
    base = cyc;
    arm(2, 5);
    while (cyc < base + 8) step();
    chk("t4_armed_pre", 32'(armed), 32'b0100);
    cancel_valid = 1'b1;
    cancel_ch    = 2'd2;
    step();
    cancel_valid = 1'b0;
    chk("t4_cancelled", 32'(armed), 32'd0);
    for (int i = 0; i < 30; i++) begin
      step();
      chk("t4_quiet", 32'({evt_valid, pending}), 32'd0);
    end
    cancel_valid = 1'b1;
    cancel_ch    = 2'd2;
    arm(2, 1);
    cancel_valid = 1'b0;
    chk("t4_start_wins", 32'(armed), 32'b0100);
    for (int i = 0; i < 12 && !evt_valid; i++) step();
    chk("t4_evt_v", 32'(evt_valid), 32'd1);
    chk("t4_evt_ch", 32'(evt_ch), 32'd2);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;

    // enable low freezes a half-counted channel
    align();
    base = cyc;
    arm(1, 2);
    while (cyc < base + 4) step();
    enable = 1'b0;
    repeat (50) step();
    chk("t5_frozen_armed", 32'(armed), 32'b0010);
    chk("t5_frozen_pend", 32'(pending), 32'd0);
    enable = 1'b1;
    base = cyc;
    while (cyc < base + 3) step();
    chk("t5_pend_early", 32'(pending), 32'd0);
    step();
    chk("t5_pend", 32'(pending), 32'b0010);
    step();
    chk("t5_evt", 32'({evt_valid, evt_ch}), 32'b101);
    arm(1, 5);
    chk("t5_committed", 32'({evt_valid, evt_ch}), 32'b101);
    chk("t5_rearmed", 32'(armed), 32'b0010);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(evt_valid), 32'd0);
    chk("t5_async_armed", 32'(armed), 32'd0);
    chk("t5_async_ch", 32'(evt_ch), 32'd0);
    step();
    #2 reset_n = 1'b1;
    ph = 0;
    chk("t5_post_rst", 32'({evt_valid, armed, pending}), 32'd0);

`ifdef TICK_SCHED_PERIODIC_EN
    // periodic ch3 count=2 expires at p0+7, p0+15, p0+23; output stalled
    base = cyc;
    start_periodic = 1'b1;
    arm(3, 2);
    start_periodic = 1'b0;
    while (cyc < base + 8) step();
    chk("p_pend1", 32'(pending), 32'b1000);
    step();
    chk("p_evt", 32'({evt_valid, evt_ch}), 32'b111);
    chk("p_armed", 32'(armed), 32'b1000);
    while (cyc < base + 16) step();
    chk("p_pend2", 32'(pending), 32'b1000);
    chk("p_ovr_pre", 32'(overrun), 32'd0);
    while (cyc < base + 24) step();
    chk("p_ovr", 32'(overrun), 32'b1000);
    chk("p_still_armed", 32'(armed), 32'b1000);
    cancel_valid = 1'b1;
    cancel_ch    = 2'd3;
    step();
    cancel_valid = 1'b0;
    chk("p_cancel", 32'({overrun, armed, pending}), 32'd0);
    chk("p_committed", 32'({evt_valid, evt_ch}), 32'b111);
    evt_ready = 1'b1;
    step();
    chk("p_drain", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
